// File: rtl/io_bank_pkg.sv
// rtl/io_bank_pkg.sv - register select codes and word-sizing helpers for the GPIO bank
package io_bank_pkg;

    typedef logic [2:0] io_reg_sel_t;

    localparam io_reg_sel_t REG_OUT     = 3'd0;
    localparam io_reg_sel_t REG_OE      = 3'd1;
    localparam io_reg_sel_t REG_OD      = 3'd2;
    localparam io_reg_sel_t REG_IN      = 3'd3;
    localparam io_reg_sel_t REG_RISE_EN = 3'd4;
    localparam io_reg_sel_t REG_FALL_EN = 3'd5;
    localparam io_reg_sel_t REG_EVT     = 3'd6;
    localparam io_reg_sel_t REG_RSVD    = 3'd7;

    function automatic int calc_nw(input int n_io, input int dw);
        return (n_io + dw - 1) / dw;
    endfunction

    // A single-word bank still keeps one word-select bit in the address.
    function automatic int calc_wb(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/io_sync_edge.sv
// rtl/io_sync_edge.sv - vectorised pad input synchroniser with previous-sample edge detect
module io_sync_edge #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] in_s,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] chain [STAGES];
    logic [W-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) chain[k] <= '0;
            prev <= '0;
        end else begin
            chain[0] <= d;
            for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
            prev <= chain[STAGES-1];
        end
    end

    assign in_s = chain[STAGES-1];
    assign rise = in_s & ~prev;
    assign fall = ~in_s & prev;

endmodule

// File: rtl/io_bank_ctrl.sv
// rtl/io_bank_ctrl.sv - GPIO bank: register file, warm-up gate, edge flags, irq and registered pad mux
module io_bank_ctrl
    import io_bank_pkg::*;
#(
    parameter int N_IO        = 48,
    parameter int SYNC_STAGES = 2,
    parameter int DW          = 32,
    localparam int NW         = calc_nw(N_IO, DW),
    localparam int WB         = calc_wb(NW),
    localparam int AW         = 3 + WB
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IO-1:0] io_in,
    output logic [N_IO-1:0] io_out,
    output logic [N_IO-1:0] io_oeb,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata,
    output logic            irq
);

    localparam int            CW       = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] WARM_MAX = CW'(SYNC_STAGES + 1);

    io_reg_sel_t      reg_sel;
    logic [WB-1:0]    word;
    logic [N_IO-1:0]  out_q, oe_q, od_q, rise_en_q, fall_en_q, evt_q;
    logic [N_IO-1:0]  out_d, oe_d, od_d, rise_en_d, fall_en_d, evt_d;
    logic [N_IO-1:0]  wmask, wbits, clr, events;
    logic [N_IO-1:0]  in_s, rise, fall, rd_vec;
    logic [NW*DW-1:0] rd_pad;
    logic [DW-1:0]    rd_words [NW];
    logic [DW-1:0]    rd_word;
    logic [CW-1:0]    warm_cnt;
    logic             warm_done;

    assign reg_sel   = addr[AW-1:WB];
    assign word      = addr[WB-1:0];
    assign warm_done = (warm_cnt == WARM_MAX);

    io_sync_edge #(.W(N_IO), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (io_in),
        .in_s  (in_s),
        .rise  (rise),
        .fall  (fall)
    );

    // Pads beyond N_IO have no lane, and out-of-range words never match a pad.
    always_comb begin
        wmask = '0;
        wbits = '0;
        for (int p = 0; p < N_IO; p++) begin
            wmask[p] = (word == WB'(p / DW));
            wbits[p] = wdata[p % DW];
        end
    end

    assign events = warm_done ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;

    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        od_d      = od_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (wr_en) begin
            case (reg_sel)
                REG_OUT:     out_d     = (out_q     & ~wmask) | (wbits & wmask);
                REG_OE:      oe_d      = (oe_q      & ~wmask) | (wbits & wmask);
                REG_OD:      od_d      = (od_q      & ~wmask) | (wbits & wmask);
                REG_RISE_EN: rise_en_d = (rise_en_q & ~wmask) | (wbits & wmask);
                REG_FALL_EN: fall_en_d = (fall_en_q & ~wmask) | (wbits & wmask);
                REG_EVT:     clr       = wbits & wmask;
                default:     ;
            endcase
        end
        // A same-cycle event overrides a clear of the same flag.
        evt_d = (evt_q & ~clr) | events;
    end

    always_comb begin
        case (reg_sel)
            REG_OUT:     rd_vec = out_q;
            REG_OE:      rd_vec = oe_q;
            REG_OD:      rd_vec = od_q;
            REG_IN:      rd_vec = in_s;
            REG_RISE_EN: rd_vec = rise_en_q;
            REG_FALL_EN: rd_vec = fall_en_q;
            REG_EVT:     rd_vec = evt_q;
            default:     rd_vec = '0;
        endcase
        rd_pad = '0;
        rd_pad[N_IO-1:0] = rd_vec;
    end

    for (genvar w = 0; w < NW; w++) begin : g_rd_word
        assign rd_words[w] = rd_pad[w*DW +: DW];
    end

    assign rd_word = (int'(word) < NW) ? rd_words[word] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt  <= '0;
            out_q     <= '0;
            oe_q      <= '0;
            od_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            evt_q     <= '0;
            io_out    <= '0;
            io_oeb    <= '1;
            rdata     <= '0;
            irq       <= 1'b0;
        end else begin
            if (!warm_done) warm_cnt <= warm_cnt + CW'(1);
            out_q     <= out_d;
            oe_q      <= oe_d;
            od_q      <= od_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            evt_q     <= evt_d;
            // Open-drain pins only ever pull low; OUT=1 releases the pad.
            io_out    <= out_d & ~od_d;
            io_oeb    <= ~(oe_d & ~(od_d & out_d));
            irq       <= |(evt_q & (rise_en_q | fall_en_q));
            if (rd_en) rdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_io_bank_ctrl.sv
// tb/tb_io_bank_ctrl.sv - randomized and directed self-checking bench for io_bank_ctrl
module tb_io_bank_ctrl;
    import io_bank_pkg::*;

    localparam int N_IO = 48;
    localparam int SS   = 2;
    localparam int DW   = 32;
    localparam int NW   = 2;
    localparam int WB   = 1;
    localparam int AW   = 3 + WB;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic            rd_en = 1'b0;
    logic [AW-1:0]   addr  = '0;
    logic [DW-1:0]   wdata = '0;
    logic [N_IO-1:0] io_in = '1;
    logic [N_IO-1:0] io_out, io_oeb;
    logic [DW-1:0]   rdata;
    logic            irq;

    io_bank_ctrl #(.N_IO(N_IO), .SYNC_STAGES(SS), .DW(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oeb (io_oeb),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference state: register contents per pad, recent io_in samples, edges since reset.
    bit [N_IO-1:0] m_out, m_oe, m_od, m_rise, m_fall, m_evt, m_prev;
    bit [N_IO-1:0] m_hist[$];
    bit [DW-1:0]   m_rdata;
    bit            m_irq;
    int            m_edges;

    function automatic void m_reset();
        m_out = '0; m_oe = '0; m_od = '0; m_rise = '0; m_fall = '0; m_evt = '0;
        m_prev = '0; m_rdata = '0; m_irq = 1'b0; m_edges = 0;
        m_hist = {};
        for (int k = 0; k < SS; k++) m_hist.push_back('0);
    endfunction

    function automatic bit [DW-1:0] m_read(input int sel, input int w);
        bit [N_IO-1:0] v;
        bit [DW-1:0]   r;
        case (sel)
            0: v = m_out;   1: v = m_oe;    2: v = m_od;   3: v = m_hist[0];
            4: v = m_rise;  5: v = m_fall;  6: v = m_evt;  default: v = '0;
        endcase
        r = '0;
        for (int i = 0; i < DW; i++)
            if (w < NW && w * DW + i < N_IO) r[i] = v[w * DW + i];
        return r;
    endfunction

    function automatic void m_step(input bit wr, input bit rd, input int sel, input int w,
                                   input bit [DW-1:0] d, input bit [N_IO-1:0] inp);
        bit [N_IO-1:0] in_s, ev, clr;
        in_s = m_hist[0];
        ev   = '0;
        if (m_edges >= SS + 1)
            ev = (in_s & ~m_prev & m_rise) | (~in_s & m_prev & m_fall);
        m_irq = |(m_evt & (m_rise | m_fall));
        if (rd) m_rdata = m_read(sel, w);
        clr = '0;
        if (wr) begin
            for (int i = 0; i < DW; i++) begin
                int p;
                p = w * DW + i;
                if (w < NW && p < N_IO) begin
                    case (sel)
                        0: m_out[p]  = d[i];
                        1: m_oe[p]   = d[i];
                        2: m_od[p]   = d[i];
                        4: m_rise[p] = d[i];
                        5: m_fall[p] = d[i];
                        6: clr[p]    = d[i];
                        default: ;
                    endcase
                end
            end
        end
        m_evt  = (m_evt & ~clr) | ev;
        m_prev = in_s;
        m_hist.push_back(inp);
        void'(m_hist.pop_front());
        m_edges++;
    endfunction

    function automatic bit [N_IO-1:0] m_oeb();
        bit [N_IO-1:0] r;
        for (int p = 0; p < N_IO; p++)
            r[p] = m_od[p] ? !(m_oe[p] && !m_out[p]) : !m_oe[p];
        return r;
    endfunction

    task automatic cycle(input bit wr, input bit rd, input int sel, input int w, input logic [DW-1:0] d);
        wr_en = wr;
        rd_en = rd;
        addr  = {sel[2:0], w[WB-1:0]};
        wdata = d;
        @(posedge clk);
        m_step(wr, rd, sel, w, d, io_in);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("io_out", io_out, m_out & ~m_od);
        chk("io_oeb", io_oeb, m_oeb());
        chk("rdata",  rdata,  m_rdata);
        chk("irq",    irq,    m_irq);
    endtask

    initial begin
        logic [63:0] rnd;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oeb",   io_oeb, 48'hFFFF_FFFF_FFFF);
        chk("rst_out",   io_out, 0);
        chk("rst_rdata", rdata,  0);
        chk("rst_irq",   irq,    0);
        rst_n = 1'b1;

        cycle(1, 0, REG_RISE_EN, 0, '1);
        cycle(1, 0, REG_RISE_EN, 1, '1);
        repeat (10) cycle(0, 0, 0, 0, 0);
        cycle(0, 1, REG_EVT, 0, 0);
        chk("warm_evt_w0", rdata, 0);
        cycle(0, 1, REG_EVT, 1, 0);
        chk("warm_evt_w1", rdata, 0);

        cycle(1, 0, REG_OE,  0, 32'h0000_00FF);
        cycle(1, 0, REG_OUT, 0, 32'h0000_00A5);
        chk("pp_oeb_lo", io_oeb[7:0],  0);
        chk("pp_out_lo", io_out[7:0],  8'hA5);
        chk("pp_oeb_hi", io_oeb[47:8], 40'hFF_FFFF_FFFF);

        cycle(1, 0, REG_OE, 1, 32'h8);
        cycle(1, 0, REG_OD, 1, 32'h8);
        chk("od_low_oeb", io_oeb[35], 0);
        chk("od_low_out", io_out[35], 0);
        cycle(1, 0, REG_OUT, 1, 32'h8);
        chk("od_rel_oeb", io_oeb[35], 1);
        chk("od_rel_out", io_out[35], 0);
        cycle(1, 0, REG_OUT, 1, 32'h0);
        chk("od_low2_oeb", io_oeb[35], 0);

        cycle(1, 0, REG_RISE_EN, 0, 32'h1);
        cycle(1, 0, REG_RISE_EN, 1, 32'h0);
        io_in = '0;
        repeat (4) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, REG_EVT, 0, '1);
        cycle(1, 0, REG_EVT, 1, '1);
        cycle(0, 0, 0, 0, 0);
        io_in[0] = 1'b1;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, REG_IN, 0, 0);
        chk("in_lat_bit0", rdata[0], 1);
        chk("irq_t2", irq, 0);
        cycle(0, 1, REG_EVT, 0, 0);
        chk("evt_bit0", rdata[0], 1);
        chk("irq_t3", irq, 1);

        cycle(1, 1, REG_OUT, 0, 32'h5A);
        chk("rw_same_pre", rdata, 32'hA5);

        cycle(1, 0, REG_EVT, 0, 32'h1);
        cycle(1, 0, REG_RISE_EN, 1, 32'h100);
        cycle(0, 0, 0, 0, 0);
        io_in[40] = 1'b1;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, REG_EVT, 1, 32'h100);
        cycle(0, 1, REG_EVT, 1, 0);
        chk("w1c_set_wins", rdata[8], 1);
        cycle(1, 0, REG_EVT, 1, 32'h100);
        chk("w1c_irq_hold", irq, 1);
        cycle(0, 1, REG_EVT, 1, 0);
        chk("w1c_cleared", rdata[8], 0);
        chk("w1c_irq_drop", irq, 0);

        cycle(1, 0, REG_OUT, 1, 32'hFFFF_FFFF);
        cycle(0, 1, REG_OUT, 1, 0);
        chk("bound_out_w1", rdata, 32'h0000_FFFF);
        cycle(1, 0, REG_RSVD, 0, 32'hFFFF_FFFF);
        cycle(0, 1, REG_RSVD, 0, 0);
        chk("rsvd_w0", rdata, 0);
        cycle(0, 1, REG_OUT, 1, 0);
        cycle(0, 1, REG_RSVD, 1, 0);
        chk("rsvd_w1", rdata, 0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) io_in[$urandom_range(0, N_IO - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) begin
                rnd   = {$urandom(), $urandom()};
                io_in = rnd[N_IO-1:0];
            end
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom());
        end

        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_oeb",   io_oeb, 48'hFFFF_FFFF_FFFF);
        chk("midrst_out",   io_out, 0);
        chk("midrst_rdata", rdata,  0);
        chk("midrst_irq",   irq,    0);
        m_reset();
        io_in = '1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 0, REG_RISE_EN, 0, '1);
        cycle(1, 0, REG_RISE_EN, 1, '1);
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 2) == 0) io_in[$urandom_range(0, N_IO - 1)] ^= 1'b1;
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bank_ctrl.md
Name: io_bank_ctrl

Overview:
- Parametrised GPIO bank controller for user designs mapped onto the fabric.
- Drives the io_in/io_out/io_oeb pad vectors that connect to the bidirectional IO BELs.
- Adds per-pin direction and open-drain mode, multi-stage input synchronisation, programmable edge capture with sticky flags and a level interrupt.
- Controlled through a simple synchronous register port from user logic; supersedes fixed-width direct pad wiring.

Parameters:
- N_IO, 48, number of pads handled (1..256).
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- DW, 32, register data width; pads are packed into NW = ceil(N_IO/DW) words.

Ports:
- clk  in  1  fabric global clock.
- rst_n  in  1  asynchronous active-low reset.
- io_in  in  N_IO  pad input values from IO BELs.
- io_out  out  N_IO  pad output values.
- io_oeb  out  N_IO  pad output-enable, active low (0 = drive).
- wr_en  in  1  register write strobe.
- rd_en  in  1  register read strobe.
- addr  in  AW  {reg_sel[2:0], word[WB-1:0]}, with WB = max(1, clog2(NW)) and AW = 3+WB.
- wdata  in  DW  write data.
- rdata  out  DW  read data, registered.
- irq  out  1  OR of all enabled sticky event flags, registered.

Behaviour:
- Reset (async assert, sync release): OUT, OE, OD, RISE_EN, FALL_EN, EVT, synchroniser and prev-sample registers = 0; rdata = 0; irq = 0; io_out = 0; io_oeb = all 1 (all pads tristated); warm-up counter = 0.
- reg_sel map:
  - 0 OUT (rw)
  - 1 OE (rw)
  - 2 OD (rw)
  - 3 IN (ro, synced value)
  - 4 RISE_EN (rw)
  - 5 FALL_EN (rw)
  - 6 EVT (w1c)
  - 7 reserved (reads 0, writes ignored)
- Bit i of word w maps to pad w*DW+i. Bits at or above N_IO read 0 and ignore writes. A word index >= NW reads 0 and ignores writes.
- Pad drive, per pin, registered directly (no combinational path from registers through logic other than this mux):
  - OD=0: io_out = OUT, io_oeb = ~OE.
  - OD=1: io_out = 0, io_oeb = ~(OE & ~OUT) (drive low only, release when OUT=1).
- Write latency: wr_en at edge t updates the register at t; io_out/io_oeb reflect it immediately after edge t.
- Read latency: rd_en at edge t loads rdata at t. rdata holds until the next rd_en.
- Simultaneous wr_en and rd_en to the same address: rdata returns the pre-write value.
- Input path: io_in passes through a SYNC_STAGES flop chain to give in_s. A change on io_in sampled at edge t appears in in_s after edge t+SYNC_STAGES-1.
- Edge detect: prev <= in_s every cycle.
  - rise = in_s & ~prev & RISE_EN; fall = ~in_s & prev & FALL_EN.
  - EVT |= rise | fall, set one edge after in_s changes.
- Warm-up: a counter runs 0..SYNC_STAGES+1 after reset and saturates. Edge events are suppressed until it saturates, so pads already high at reset release produce no spurious rising events.
- EVT write-1-to-clear. If a set and a clear hit the same bit in the same cycle, the set wins (flag stays 1).
- irq <= |(EVT & (RISE_EN | FALL_EN)), registered one cycle after EVT. Disabling both enables for a pin masks its flag from irq but does not clear it.
- Reset asserted mid-operation: all state returns to reset values asynchronously; pads tristate within the same cycle.

Decomposition:
- Package io_bank_pkg holds:
  - reg_sel localparams REG_OUT..REG_RSVD;
  - a function computing NW and WB;
  - the io_reg_sel_t typedef (3 bits).
- Sub-module io_sync_edge (one instance per pin or vectorised N_IO wide), containing the synchroniser chain, prev register and rise/fall outputs.
- Register file, warm-up counter and pad mux stay in io_bank_ctrl.

Test Plan:
- Reset: hold rst_n=0 with io_in=all 1 -> io_oeb=all 1, io_out=0, rdata=0, irq=0. Release reset -> EVT reads 0 on both words after 10 cycles even with RISE_EN=all 1 written immediately.
- Push-pull output: write OE word0 = 0x0000_00FF, OUT word0 = 0x0000_00A5 -> io_oeb[7:0]=0x00, io_out[7:0]=0xA5 on the cycle after the write; io_oeb[47:8] remain 1.
- Open-drain: OD word1 bit 3 = 1, OE = 1, then toggle OUT bit 3 -> pad 35 has io_oeb=0 with io_out=0 when OUT=0, and io_oeb=1 when OUT=1.
- Input latency and edge capture: RISE_EN word0 = 0x1; drive io_in[0] 0->1 at edge t -> IN word0 bit 0 reads 1 from a read at edge t+2 onward; EVT bit0 = 1 at t+2; irq = 1 at t+3.
- W1C collision: with a rising edge on pad 40 arriving in the same cycle as a write of EVT word1 = 0x100 -> bit 8 stays 1. A second W1C with no edge clears it, and irq drops one cycle later.
- Bounds: write 0xFFFF_FFFF to OUT word1 -> read back 0x0000_FFFF. A read of any address with reg_sel 7 returns 0.
